// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// ------------
// Stall/flush sequencer for the 5-stage integer core. It lives in ID next to
// the forwarding unit. It detects the hazards that forwarding cannot cover:
//   * load-use: a load in ID-EX whose destination the ID instruction reads
//   * branch operands compared in ID: an ALU writer still in ID-EX, or a load
//     in EX-MEM (an ALU result in EX-MEM is forwarded to ID and is not a hazard)
//   * the multi-cycle mult/div unit: any mult/div or mfhi/mflo arriving in ID
//     while the unit is busy
// From these it drives the PC and IF-ID write enables, ID-EX bubble insertion
// and the IF-ID flush. It also sequences the mult/div unit (start pulse,
// busy, done) and keeps a saturating count of stalled cycles.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   if_id_rs, if_id_rt            source registers of the ID instruction
//   if_id_uses_rt                 ID instruction reads rt
//   if_id_branch                  ID instruction is a branch compared in ID
//   if_id_md_op, if_id_is_div     ID instruction is mult (0) / div (1)
//   if_id_md_read                 ID instruction is mfhi/mflo
//   branch_taken                  branch in ID resolves taken
//   id_ex_dst, ex_mem_dst         destination registers in EX / MEM
//   id_ex_regwrite, ex_mem_regwrite  register write, active-low (0 = writes)
//   id_ex_memread, ex_mem_memread    stage holds a load
//   stall_cnt_clr                 synchronous clear of stall_cnt
//   pc_write, if_id_write         1 = update
//   id_ex_bubble                  1 = load NOP into ID-EX
//   if_id_flush                   1 = squash IF-ID
//   md_start, md_busy, md_done    mult/div sequencing
//   stall_cnt                     saturating stalled-cycle count
//
// Handshake with the mult/div unit: md_start is a single-cycle command, never
// issued in a stalled cycle. md_busy is high from the cycle after md_start for
// exactly LAT cycles; md_done marks the last of those cycles, and HI/LO are
// written at its closing edge. There is no back-pressure from the unit.

module hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int STALL_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         if_id_rs,
    input  logic [4:0]         if_id_rt,
    input  logic               if_id_uses_rt,
    input  logic               if_id_branch,
    input  logic               if_id_md_op,
    input  logic               if_id_is_div,
    input  logic               if_id_md_read,
    input  logic               branch_taken,
    input  logic [4:0]         id_ex_dst,
    input  logic [4:0]         ex_mem_dst,
    input  logic               id_ex_regwrite,
    input  logic               ex_mem_regwrite,
    input  logic               id_ex_memread,
    input  logic               ex_mem_memread,
    input  logic               stall_cnt_clr,
    output logic               pc_write,
    output logic               if_id_write,
    output logic               id_ex_bubble,
    output logic               if_id_flush,
    output logic               md_start,
    output logic               md_busy,
    output logic               md_done,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [5:0]         MULT_CNT = 6'(MULT_LAT);
    localparam logic [5:0]         DIV_CNT  = 6'(DIV_LAT);
    localparam logic [STALL_W-1:0] CNT_MAX  = '1;

    md_state_t  state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    logic id_ex_match, ex_mem_match;
    logic load_use, branch_haz, md_haz, stall;

    // Source match against a producing stage; regwrite is active-low and
    // register 0 never counts as a producer.
    always_comb begin
        id_ex_match  = (id_ex_dst != 5'd0) && !id_ex_regwrite &&
                       ((id_ex_dst == if_id_rs) ||
                        (if_id_uses_rt && (id_ex_dst == if_id_rt)));
        ex_mem_match = (ex_mem_dst != 5'd0) && !ex_mem_regwrite &&
                       ((ex_mem_dst == if_id_rs) ||
                        (if_id_uses_rt && (ex_mem_dst == if_id_rt)));
    end

    always_comb begin
        load_use   = id_ex_memread && id_ex_match;
        // Any ID-EX writer blocks a branch (ALU or load); from EX-MEM only a
        // load does, since ALU results there are forwarded into ID.
        branch_haz = if_id_branch &&
                     (id_ex_match || (ex_mem_memread && ex_mem_match));
        md_haz     = (state_q == BUSY) && (if_id_md_op || if_id_md_read);
        stall      = load_use || branch_haz || md_haz;
    end

    // While reset is held the pipeline is frozen with a bubble in ID-EX.
    always_comb begin
        pc_write     = rst_n && !stall;
        if_id_write  = rst_n && !stall;
        id_ex_bubble = !rst_n || stall;
        if_id_flush  = rst_n && branch_taken && !stall;
        md_busy      = (state_q == BUSY);
    end

    // Mult/div sequencer: next state and start/done outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_start = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && if_id_md_op && !stall) begin
                    md_start = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = if_id_is_div ? DIV_CNT : MULT_CNT;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    md_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear takes priority; the clearing cycle itself is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic.
// The driver issues one pipeline cycle at a time and pushes the expected
// output vector from a behavioural model; a negedge monitor pops and compares.

module tb_hazard_ctrl;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;
    localparam int STALL_W  = 16;
    localparam int CNT_TOP  = (1 << STALL_W) - 1;
    localparam int VW       = 7 + STALL_W;

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses_rt, branch, md_op, is_div, md_read, taken;
        logic [4:0] ex_dst, mem_dst;
        logic       ex_rw, mem_rw, ex_mr, mem_mr, clr;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] if_id_rs, if_id_rt, id_ex_dst, ex_mem_dst;
    logic if_id_uses_rt, if_id_branch, if_id_md_op, if_id_is_div, if_id_md_read;
    logic branch_taken, id_ex_regwrite, ex_mem_regwrite, id_ex_memread;
    logic ex_mem_memread, stall_cnt_clr;
    logic pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic md_start, md_busy, md_done;
    logic [STALL_W-1:0] stall_cnt;

    logic [VW-1:0] exp_q[$];
    string         tag_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    // Reference state: cycles of mult/div work still outstanding, and count.
    int md_rem = 0;
    int m_cnt  = 0;

    hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .if_id_branch(if_id_branch), .if_id_md_op(if_id_md_op),
        .if_id_is_div(if_id_is_div), .if_id_md_read(if_id_md_read),
        .branch_taken(branch_taken), .id_ex_dst(id_ex_dst), .ex_mem_dst(ex_mem_dst),
        .id_ex_regwrite(id_ex_regwrite), .ex_mem_regwrite(ex_mem_regwrite),
        .id_ex_memread(id_ex_memread), .ex_mem_memread(ex_mem_memread),
        .stall_cnt_clr(stall_cnt_clr),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .md_start(md_start), .md_busy(md_busy),
        .md_done(md_done), .stall_cnt(stall_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic cyc_t nop();
        cyc_t c;
        c.rs = 5'd0; c.rt = 5'd0; c.uses_rt = 1'b0; c.branch = 1'b0;
        c.md_op = 1'b0; c.is_div = 1'b0; c.md_read = 1'b0; c.taken = 1'b0;
        c.ex_dst = 5'd0; c.mem_dst = 5'd0;
        c.ex_rw = 1'b1; c.mem_rw = 1'b1; c.ex_mr = 1'b0; c.mem_mr = 1'b0;
        c.clr = 1'b0;
        return c;
    endfunction

    // Does the ID instruction read register d? (r0 is never a dependency)
    function automatic bit reads(input cyc_t c, input logic [4:0] d);
        if (d == 5'd0) return 1'b0;
        return (c.rs == d) || (c.uses_rt && c.rt == d);
    endfunction

    task automatic apply(input cyc_t c);
        if_id_rs = c.rs; if_id_rt = c.rt; if_id_uses_rt = c.uses_rt;
        if_id_branch = c.branch; if_id_md_op = c.md_op; if_id_is_div = c.is_div;
        if_id_md_read = c.md_read; branch_taken = c.taken;
        id_ex_dst = c.ex_dst; ex_mem_dst = c.mem_dst;
        id_ex_regwrite = c.ex_rw; ex_mem_regwrite = c.mem_rw;
        id_ex_memread = c.ex_mr; ex_mem_memread = c.mem_mr;
        stall_cnt_clr = c.clr;
    endtask

    // One pipeline cycle: called at posedge+1, returns at next posedge+1.
    task automatic cycle(input cyc_t c, input string tag);
        logic [VW-1:0] e;
        bit ex_w, mem_w, busy, done, st, start;
        apply(c);
        busy = 0; start = 0; st = 0;
        if (!rst_n) begin
            e = {1'b0, 1'b0, 1'b1, 4'b0000, STALL_W'(0)};
        end else begin
            ex_w  = !c.ex_rw  && reads(c, c.ex_dst);
            mem_w = !c.mem_rw && reads(c, c.mem_dst);
            busy  = (md_rem > 0);
            done  = (md_rem == 1);
            st    = (c.ex_mr && ex_w) ||
                    (c.branch && (ex_w || (c.mem_mr && mem_w))) ||
                    (busy && (c.md_op || c.md_read));
            start = !busy && c.md_op && !st;
            e = {!st, !st, st, c.taken && !st, start, busy, done, STALL_W'(m_cnt)};
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        if (!rst_n) begin
            md_rem = 0;
            m_cnt  = 0;
        end else begin
            if (busy) md_rem = md_rem - 1;
            if (start) md_rem = c.is_div ? DIV_LAT : MULT_LAT;
            if (c.clr) m_cnt = 0;
            else if (st && m_cnt < CNT_TOP) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [VW-1:0] e, a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {pc_write, if_id_write, id_ex_bubble, if_id_flush,
                 md_start, md_busy, md_done, stall_cnt};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s @%0t: {pcw,ifw,bub,fl,st,busy,done,cnt} got %h expected %h",
                         t, $time, a, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cyc_t c;
        apply(nop());
        @(posedge clk); #1;

        // reset values
        cycle(nop(), "reset");
        c = nop(); c.taken = 1; c.md_op = 1;
        cycle(c, "reset_inputs");
        rst_n = 1'b1;
        cycle(nop(), "first_cycle");

        // load-use: lw r5 in EX, add r?,r5 in ID
        c = nop(); c.clr = 1; cycle(c, "clr");
        c = nop(); c.rs = 5; c.ex_dst = 5; c.ex_rw = 0; c.ex_mr = 1;
        cycle(c, "load_use");
        c = nop(); c.rs = 5; c.mem_dst = 5; c.mem_rw = 0; c.mem_mr = 1;
        cycle(c, "load_use_adv");
        check_val("load_use_cnt", int'(stall_cnt), 1);

        // no stall: dst = 0, or regwrite deasserted, or rt unused
        c = nop(); c.rs = 0; c.ex_dst = 0; c.ex_rw = 0; c.ex_mr = 1;
        cycle(c, "load_use_r0");
        c = nop(); c.rs = 5; c.ex_dst = 5; c.ex_rw = 1; c.ex_mr = 1;
        cycle(c, "load_use_norw");
        c = nop(); c.rt = 6; c.uses_rt = 0; c.ex_dst = 6; c.ex_rw = 0; c.ex_mr = 1;
        cycle(c, "load_use_rt_unused");
        c.uses_rt = 1;
        cycle(c, "load_use_rt");

        // branch directly after lw r7: two stalls, then taken flush
        c = nop(); c.clr = 1; cycle(c, "clr");
        c = nop(); c.branch = 1; c.rs = 7; c.taken = 1;
        c.ex_dst = 7; c.ex_rw = 0; c.ex_mr = 1;
        cycle(c, "br_lw_1");
        c = nop(); c.branch = 1; c.rs = 7; c.taken = 1;
        c.mem_dst = 7; c.mem_rw = 0; c.mem_mr = 1;
        cycle(c, "br_lw_2");
        c = nop(); c.branch = 1; c.rs = 7; c.taken = 1;
        cycle(c, "br_lw_flush");
        check_val("br_lw_cnt", int'(stall_cnt), 2);

        // branch after ALU writer: one stall, EX-MEM ALU result forwarded
        c = nop(); c.branch = 1; c.rt = 9; c.uses_rt = 1; c.taken = 1;
        c.ex_dst = 9; c.ex_rw = 0;
        cycle(c, "br_alu_1");
        c = nop(); c.branch = 1; c.rt = 9; c.uses_rt = 1; c.taken = 1;
        c.mem_dst = 9; c.mem_rw = 0;
        cycle(c, "br_alu_fwd");

        // div then immediate mflo: 32 stalls, advances on the 33rd cycle
        c = nop(); c.clr = 1; cycle(c, "clr");
        c = nop(); c.md_op = 1; c.is_div = 1; cycle(c, "div_start");
        c = nop(); c.md_read = 1;
        for (int i = 0; i < DIV_LAT + 1; i++) cycle(c, "div_mflo");
        check_val("div_cnt", int'(stall_cnt), DIV_LAT);
        cycle(nop(), "div_idle");

        // mult, 3 independent, mfhi: one stall
        c = nop(); c.clr = 1; cycle(c, "clr");
        c = nop(); c.md_op = 1; cycle(c, "mult_start");
        for (int i = 0; i < 3; i++) cycle(nop(), "mult_indep");
        c = nop(); c.md_read = 1;
        cycle(c, "mfhi_stall");
        cycle(c, "mfhi_adv");
        check_val("mult_cnt", int'(stall_cnt), 1);

        // load-use coinciding with md hazard counts once
        c = nop(); c.clr = 1; cycle(c, "clr");
        c = nop(); c.md_op = 1; cycle(c, "mult_start2");
        c = nop(); c.md_read = 1; c.rs = 4; c.ex_dst = 4; c.ex_rw = 0; c.ex_mr = 1;
        cycle(c, "lu_and_md");
        check_val("overlap_cnt", int'(stall_cnt), 1);
        for (int i = 0; i < MULT_LAT; i++) cycle(nop(), "drain");

        // reset in the middle of a div
        c = nop(); c.md_op = 1; c.is_div = 1; cycle(c, "div_start_rst");
        for (int i = 0; i < 5; i++) cycle(nop(), "div_busy");
        rst_n = 1'b0;
        cycle(nop(), "rst_mid_busy");
        cycle(nop(), "rst_hold");
        rst_n = 1'b1;
        c = nop(); c.md_read = 1;
        cycle(c, "mflo_after_rst");
        for (int i = 0; i < DIV_LAT; i++) cycle(nop(), "no_done_after_rst");

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            c = nop();
            c.rs      = 5'($urandom_range(0, 3));
            c.rt      = 5'($urandom_range(0, 3));
            c.uses_rt = 1'($urandom_range(0, 1));
            c.branch  = ($urandom_range(0, 2) == 0);
            c.taken   = 1'($urandom_range(0, 1));
            c.md_op   = ($urandom_range(0, 9) == 0);
            c.is_div  = ($urandom_range(0, 3) == 0);
            c.md_read = ($urandom_range(0, 5) == 0);
            c.ex_dst  = 5'($urandom_range(0, 3));
            c.mem_dst = 5'($urandom_range(0, 3));
            c.ex_rw   = 1'($urandom_range(0, 1));
            c.mem_rw  = 1'($urandom_range(0, 1));
            c.ex_mr   = 1'($urandom_range(0, 1));
            c.mem_mr  = 1'($urandom_range(0, 1));
            c.clr     = ($urandom_range(0, 63) == 0);
            cycle(c, "random");
        end
        for (int i = 0; i < DIV_LAT + 1; i++) cycle(nop(), "rand_drain");

        // saturation, then clear winning over a stalled cycle
        c = nop(); c.clr = 1; cycle(c, "clr");
        c = nop(); c.rs = 3; c.ex_dst = 3; c.ex_rw = 0; c.ex_mr = 1;
        for (int i = 0; i < CNT_TOP + 6; i++) cycle(c, "saturate");
        check_val("sat_cnt", int'(stall_cnt), CNT_TOP);
        c.clr = 1;
        cycle(c, "clr_while_stall");
        check_val("clr_cnt", int'(stall_cnt), 0);
        c.clr = 0;
        cycle(c, "count_after_clr");
        check_val("count_after_clr", int'(stall_cnt), 1);

        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
